// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that multiplexes NREQ producers onto
// the write port of a single shared fifo. Multi-beat bursts (closed by
// req_last) hold the grant until their final beat so they never interleave.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no burst open; winner picked combinationally, searching from rr_ptr
// LOCKED | burst open; owner keeps the write port until its last beat lands
module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_mask,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_din,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } st_t;

  st_t            st, st_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0] owner, owner_nxt;

  logic [NREQ-1:0] elig;
  logic            elig_any;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  sel;
  logic            sel_def;
  logic            sel_vld;
  logic            sel_last;
  logic            acc;

  // Modulo-NREQ increment; explicit wrap keeps non-power-of-2 NREQ legal.
  function automatic logic [IDW-1:0] idx_inc(input logic [IDW-1:0] v);
    if (v == IDW'(NREQ - 1)) begin
      return '0;
    end
    return v + IDW'(1);
  endfunction

  // Round-robin search: first eligible index starting at rr_ptr, wrapping.
  always_comb begin
    logic [IDW:0] cand;
    elig     = req_valid & req_mask;
    elig_any = 1'b0;
    win      = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!elig_any && elig[cand[IDW-1:0]]) begin
        elig_any = 1'b1;
        win      = cand[IDW-1:0];
      end
    end
  end

  // Current selection: locked owner wins unconditionally; while reset is held
  // the write port is kept quiet even if producers still present valid.
  always_comb begin
    sel     = '0;
    sel_def = 1'b0;
    sel_vld = 1'b0;
    if (st == LOCKED) begin
      sel     = owner;
      sel_def = 1'b1;
      sel_vld = req_valid[owner];
    end else begin
      sel     = win;
      sel_def = elig_any;
      sel_vld = elig_any;
    end
    if (!rst_n) begin
      sel     = '0;
      sel_def = 1'b0;
      sel_vld = 1'b0;
    end
    sel_last = req_last[sel];
    acc      = sel_vld & ~fifo_full;
  end

  // Write-port and handshake outputs, all combinational from state + inputs.
  always_comb begin
    req_ready  = '0;
    fifo_din   = '0;
    fifo_wr_en = acc;
    grant_id   = sel_def ? sel : '0;
    busy       = (st == LOCKED);
    for (int i = 0; i < NREQ; i++) begin
      if (sel_def && (sel == IDW'(i))) begin
        fifo_din     = req_data[i*DWIDTH +: DWIDTH];
        req_ready[i] = acc;
      end
    end
  end

  // Next-state: only an accepted beat moves the arbiter.
  always_comb begin
    st_nxt     = st;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    if (acc) begin
      unique case (st)
        IDLE: begin
          if (sel_last) begin
            rr_ptr_nxt = idx_inc(sel);
          end else begin
            st_nxt    = LOCKED;
            owner_nxt = sel;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            st_nxt     = IDLE;
            rr_ptr_nxt = idx_inc(owner);
          end
        end
        default: begin
          st_nxt = IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      st     <= st_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner  <= owner_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a 4-requester and a 3-requester instance, driven
// from per-requester beat queues, checked every cycle against a rule-level
// model, plus literal expectations on the sequence of written beats.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NREQ=4
  logic [3:0]  a_valid = '0, a_last = '0, a_mask = '0, a_ready;
  logic [31:0] a_data = '0;
  logic        a_full = 1'b0, a_wr, a_busy;
  logic [7:0]  a_din;
  logic [1:0]  a_gid;

  // Instance B: NREQ=3
  logic [2:0]  b_valid = '0, b_last = '0, b_mask = '0, b_ready;
  logic [23:0] b_data = '0;
  logic        b_full = 1'b0, b_wr, b_busy;
  logic [7:0]  b_din;
  logic [1:0]  b_gid;

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_last(a_last),
    .req_data(a_data), .req_ready(a_ready), .req_mask(a_mask),
    .fifo_full(a_full), .fifo_wr_en(a_wr), .fifo_din(a_din),
    .grant_id(a_gid), .busy(a_busy)
  );

  fifo_wr_arbiter #(.NREQ(3), .DWIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_last(b_last),
    .req_data(b_data), .req_ready(b_ready), .req_mask(b_mask),
    .fifo_full(b_full), .fifo_wr_en(b_wr), .fifo_din(b_din),
    .grant_id(b_gid), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  // Producer beat queues: {last, data}
  logic [8:0] qa [4][$];
  logic [8:0] qb [3][$];
  logic [3:0] a_seen = '0;
  logic [2:0] b_seen = '0;

  // Log of written beats
  int la_gid[$], la_din[$], la_busy[$];
  int lb_gid[$], lb_din[$], lb_busy[$];

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic [3:0] ready;
    int         gid;
    logic       busy;
    bit         n_locked;
    int         n_owner;
    int         n_ptr;
  } mres_t;

  // Rule-level model: who is selected, whether the beat goes in, where the
  // round-robin pointer lands afterwards.
  function automatic mres_t model(input int n, input bit locked, input int owner,
                                  input int ptr, input logic [3:0] valid,
                                  input logic [3:0] last, input logic [3:0] mask,
                                  input logic [31:0] data, input logic full,
                                  input logic rstn);
    mres_t r;
    int    sel;
    bit    have;
    bit    sv;
    r.wr = 1'b0; r.din = '0; r.ready = '0; r.gid = 0; r.busy = 1'b0;
    r.n_locked = locked; r.n_owner = owner; r.n_ptr = ptr;
    if (!rstn) begin
      r.n_locked = 1'b0; r.n_owner = 0; r.n_ptr = 0;
      return r;
    end
    r.busy = locked;
    sel = 0; have = 1'b0; sv = 1'b0;
    if (locked) begin
      sel = owner; have = 1'b1; sv = valid[owner];
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (ptr + k) % n;
        if (!have && valid[i] && mask[i]) begin
          sel = i; have = 1'b1; sv = 1'b1;
        end
      end
    end
    if (have) begin
      r.gid = sel;
      r.din = data[sel*8 +: 8];
    end
    if (have && sv && !full) begin
      r.wr = 1'b1;
      r.ready[sel] = 1'b1;
      if (last[sel]) begin
        r.n_locked = 1'b0;
        r.n_ptr = (sel + 1) % n;
      end else begin
        r.n_locked = 1'b1;
        r.n_owner = sel;
      end
    end
    return r;
  endfunction

  bit    ma_locked = 1'b0, mb_locked = 1'b0;
  int    ma_owner = 0, ma_ptr = 0, mb_owner = 0, mb_ptr = 0;
  mres_t ra, rb;

  // Model state advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    ra = model(4, ma_locked, ma_owner, ma_ptr, a_valid, a_last, a_mask, a_data, a_full, rst_n);
    rb = model(3, mb_locked, mb_owner, mb_ptr, {1'b0, b_valid}, {1'b0, b_last},
               {1'b0, b_mask}, {8'h00, b_data}, b_full, rst_n);
    ma_locked <= ra.n_locked; ma_owner <= ra.n_owner; ma_ptr <= ra.n_ptr;
    mb_locked <= rb.n_locked; mb_owner <= rb.n_owner; mb_ptr <= rb.n_ptr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    mres_t ea, eb;
    ea = model(4, ma_locked, ma_owner, ma_ptr, a_valid, a_last, a_mask, a_data, a_full, rst_n);
    eb = model(3, mb_locked, mb_owner, mb_ptr, {1'b0, b_valid}, {1'b0, b_last},
               {1'b0, b_mask}, {8'h00, b_data}, b_full, rst_n);
    chk("a_wr_en", a_wr, ea.wr);
    chk("a_din", a_din, ea.din);
    chk("a_ready", a_ready, ea.ready);
    chk("a_grant_id", a_gid, ea.gid);
    chk("a_busy", a_busy, ea.busy);
    chk("b_wr_en", b_wr, eb.wr);
    chk("b_din", b_din, eb.din);
    chk("b_ready", {1'b0, b_ready}, eb.ready);
    chk("b_grant_id", b_gid, eb.gid);
    chk("b_busy", b_busy, eb.busy);
    chk("b_grant_legal", (b_gid < 2'd3), 1);
    if (a_wr === 1'b1) begin
      la_gid.push_back(int'(a_gid)); la_din.push_back(int'(a_din)); la_busy.push_back(int'(a_busy));
    end
    if (b_wr === 1'b1) begin
      lb_gid.push_back(int'(b_gid)); lb_din.push_back(int'(b_din)); lb_busy.push_back(int'(b_busy));
    end
    a_seen = a_ready;
    b_seen = b_ready;
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (qa[i].size() > 0) begin
        a_valid[i] = 1'b1; {a_last[i], a_data[i*8 +: 8]} = qa[i][0];
      end else begin
        a_valid[i] = 1'b0; a_last[i] = 1'b0; a_data[i*8 +: 8] = 8'h00;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (qb[i].size() > 0) begin
        b_valid[i] = 1'b1; {b_last[i], b_data[i*8 +: 8]} = qb[i][0];
      end else begin
        b_valid[i] = 1'b0; b_last[i] = 1'b0; b_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One cycle: compare at the falling edge, then retire accepted beats
  // shortly after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (a_seen[i] && qa[i].size() > 0) void'(qa[i].pop_front());
    for (int i = 0; i < 3; i++)
      if (b_seen[i] && qb[i].size() > 0) void'(qb[i].pop_front());
    refresh();
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < 4; i++) if (qa[i].size() > 0) return 1'b0;
    for (int i = 0; i < 3; i++) if (qb[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input int max);
    int c;
    c = 0;
    while (!queues_empty() && c < max) begin
      tick();
      c++;
    end
    chk({nm, " drain"}, queues_empty(), 1);
  endtask

  task automatic chk_la(input string nm, input int idx, input int g, input int d, input int b);
    if (idx < la_gid.size()) begin
      chk($sformatf("%s[%0d] gid", nm, idx), la_gid[idx], g);
      chk($sformatf("%s[%0d] din", nm, idx), la_din[idx], d);
      chk($sformatf("%s[%0d] busy", nm, idx), la_busy[idx], b);
    end else begin
      chk($sformatf("%s[%0d] present", nm, idx), la_gid.size(), idx + 1);
    end
  endtask

  task automatic chk_lb(input string nm, input int idx, input int g, input int d);
    if (idx < lb_gid.size()) begin
      chk($sformatf("%s[%0d] gid", nm, idx), lb_gid[idx], g);
      chk($sformatf("%s[%0d] din", nm, idx), lb_din[idx], d);
    end else begin
      chk($sformatf("%s[%0d] present", nm, idx), lb_gid.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int eg[8];
    int ed[8];
    int eb[8];

    a_mask = 4'hF;
    b_mask = 3'h7;
    // Round-robin single beats; valid already high while reset is held.
    for (int i = 0; i < 4; i++) begin
      qa[i].push_back({1'b1, 8'hA0 + 8'(i)});
      qa[i].push_back({1'b1, 8'hA0 + 8'(i)});
    end
    refresh();
    tick();
    tick();
    chk("reset wr_en", a_wr, 0);
    chk("reset ready", a_ready, 0);
    chk("reset busy", a_busy, 0);
    chk("reset grant_id", a_gid, 0);
    chk("reset din", a_din, 0);
    rst_n = 1'b1;
    base = la_gid.size();
    drain("rr", 20);
    chk("rr count", la_gid.size() - base, 8);
    for (int k = 0; k < 8; k++) chk_la("rr", base + k, k % 4, 8'hA0 + (k % 4), 0);

    // Burst lock: req1 3-beat burst while req0/req2 keep requesting.
    qa[0].push_back({1'b1, 8'hB0}); qa[0].push_back({1'b1, 8'hB1});
    qa[1].push_back({1'b0, 8'h11}); qa[1].push_back({1'b0, 8'h12}); qa[1].push_back({1'b1, 8'h13});
    qa[2].push_back({1'b1, 8'hB2});
    refresh();
    base = la_gid.size();
    drain("burst", 20);
    eg = '{0, 1, 1, 1, 2, 0, 0, 0};
    ed = '{8'hB0, 8'h11, 8'h12, 8'h13, 8'hB2, 8'hB1, 0, 0};
    eb = '{0, 0, 1, 1, 0, 0, 0, 0};
    chk("burst count", la_gid.size() - base, 6);
    for (int k = 0; k < 6; k++) chk_la("burst", base + k, eg[k], ed[k], eb[k]);

    // Backpressure in the middle of req3's 2-beat burst.
    qa[3].push_back({1'b0, 8'h31}); qa[3].push_back({1'b1, 8'h32});
    refresh();
    base = la_gid.size();
    tick();
    a_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall wr_en", a_wr, 0);
      chk("stall ready", a_ready, 0);
      chk("stall busy", a_busy, 1);
      chk("stall grant_id", a_gid, 3);
    end
    chk("stall writes", la_gid.size() - base, 1);
    a_full = 1'b0;
    drain("bp", 10);
    chk_la("bp", base, 3, 8'h31, 0);
    chk_la("bp", base + 1, 3, 8'h32, 1);
    chk("bp busy after", a_busy, 0);

    // Stalled IDLE latches nothing: a later request nearer rr_ptr wins.
    a_full = 1'b1;
    qa[2].push_back({1'b1, 8'hC2});
    refresh();
    base = la_gid.size();
    tick();
    tick();
    qa[0].push_back({1'b1, 8'hC0});
    refresh();
    tick();
    chk("idle stall writes", la_gid.size() - base, 0);
    a_full = 1'b0;
    drain("idle stall", 10);
    chk_la("idle stall", base, 0, 8'hC0, 0);
    chk_la("idle stall", base + 1, 2, 8'hC2, 0);

    // Masking: only 0 and 2 may be served.
    a_mask = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      qa[i].push_back({1'b1, 8'hD0 + 8'(i)});
      qa[i].push_back({1'b1, 8'hE0 + 8'(i)});
    end
    refresh();
    base = la_gid.size();
    for (int c = 0; c < 20 && (qa[0].size() > 0 || qa[2].size() > 0); c++) tick();
    repeat (3) tick();
    chk("mask count", la_gid.size() - base, 4);
    chk("mask q1 untouched", qa[1].size(), 2);
    chk("mask q3 untouched", qa[3].size(), 2);
    chk_la("mask", base, 0, 8'hD0, 0);
    chk_la("mask", base + 1, 2, 8'hD2, 0);
    chk_la("mask", base + 2, 0, 8'hE0, 0);
    chk_la("mask", base + 3, 2, 8'hE2, 0);
    a_mask = 4'hF;
    base = la_gid.size();
    drain("unmask", 20);
    chk_la("unmask", base, 3, 8'hD3, 0);
    chk_la("unmask", base + 1, 1, 8'hD1, 0);
    chk_la("unmask", base + 2, 3, 8'hE3, 0);
    chk_la("unmask", base + 3, 1, 8'hE1, 0);

    // Async reset pulse in the middle of req2's burst.
    qa[2].push_back({1'b0, 8'h21}); qa[2].push_back({1'b0, 8'h22}); qa[2].push_back({1'b1, 8'h23});
    refresh();
    base = la_gid.size();
    tick();
    qa[0].push_back({1'b1, 8'h50});
    qa[1].push_back({1'b1, 8'h51});
    qa[3].push_back({1'b1, 8'h53});
    refresh();
    chk("pre-reset busy", a_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst wr_en", a_wr, 0);
    chk("async rst ready", a_ready, 0);
    chk("async rst busy", a_busy, 0);
    chk("async rst grant_id", a_gid, 0);
    chk("async rst din", a_din, 0);
    #1 rst_n = 1'b1;
    drain("post reset", 20);
    chk_la("rst", base, 2, 8'h21, 0);
    chk_la("rst", base + 1, 0, 8'h50, 0);
    chk_la("rst", base + 2, 1, 8'h51, 0);
    chk_la("rst", base + 3, 2, 8'h22, 0);
    chk_la("rst", base + 4, 2, 8'h23, 1);
    chk_la("rst", base + 5, 3, 8'h53, 0);

    // NREQ=3: pointer wraps 2 -> 0.
    for (int i = 0; i < 3; i++) begin
      qb[i].push_back({1'b1, 8'h60 + 8'(i)});
      qb[i].push_back({1'b1, 8'h70 + 8'(i)});
    end
    refresh();
    drain("nreq3", 20);
    chk("nreq3 count", lb_gid.size(), 6);
    for (int k = 0; k < 6; k++) chk_lb("nreq3", k, k % 3, (k < 3 ? 8'h60 : 8'h70) + (k % 3));

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
